// File: rtl/event_generator_unit_req_sequencer.sv
// ---------------------------------------------------------------------------
// event_generator_unit_req_sequencer
//
// Clock/power resource request sequencer between the EGU channel logic and
// the PCGC. Each channel maps onto a static subset of resource pairs; every
// pair runs a four-phase req/ack handshake with a hold-off hysteresis before
// it is released. Per-channel grants report when all required pairs are up.
//
// Optional feature macro: EVENT_GENERATOR_UNIT_REQ_TIMEOUT_EN
//   defined     -> per-pair handshake timeout counters and sticky reqTimeout
//   not defined -> reqTimeout tied to 0, timeoutClear ignored
//
// Ports:
//   clk           in   block clock
//   reset         in   asynchronous, active-high reset
//   chReq         in   [NUM_CHANNELS]       per-channel demand (level)
//   chPairMask    in   [NUM_CHANNELS*NUM_CLOCK_POWER_PAIR]
//                      bit [c*NUM_CLOCK_POWER_PAIR+p]: channel c needs pair p
//   ackResources  in   [NUM_CLOCK_POWER_PAIR] PCGC acknowledge per pair
//   timeoutClear  in   clears all sticky timeout flags
//   reqResources  out  [NUM_CLOCK_POWER_PAIR] registered request to the PCGC
//   chGrant       out  [NUM_CHANNELS]       registered grant per channel
//   reqTimeout    out  [NUM_CLOCK_POWER_PAIR] sticky handshake timeout flag
// ---------------------------------------------------------------------------
module event_generator_unit_req_sequencer #(
    parameter int unsigned INCLUDE_EVENT_GENERATOR_UNIT = 1,
    parameter int unsigned NUM_CLOCK_POWER_PAIR         = 2,
    parameter int unsigned NUM_CHANNELS                 = 4,
    parameter int unsigned HOLD_CYCLES                  = 8,
    parameter int unsigned TIMEOUT_CYCLES               = 255
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_CHANNELS-1:0]                      chReq,
    input  logic [NUM_CHANNELS*NUM_CLOCK_POWER_PAIR-1:0] chPairMask,
    input  logic [NUM_CLOCK_POWER_PAIR-1:0]              ackResources,
    input  logic                                         timeoutClear,
    output logic [NUM_CLOCK_POWER_PAIR-1:0]              reqResources,
    output logic [NUM_CHANNELS-1:0]                      chGrant,
    output logic [NUM_CLOCK_POWER_PAIR-1:0]              reqTimeout
);

    localparam int unsigned NP     = NUM_CLOCK_POWER_PAIR;
    localparam int unsigned NC     = NUM_CHANNELS;
    // Guard against a zero-width counter when hysteresis is disabled.
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } pair_state_e;

    generate
        if (INCLUDE_EVENT_GENERATOR_UNIT != 0) begin : g_unit

            pair_state_e       state_q [NP];
            pair_state_e       state_n [NP];
            logic [HOLD_W-1:0] hold_q  [NP];
            logic [HOLD_W-1:0] hold_n  [NP];
            logic [NP-1:0]     demand_c;
            logic [NP-1:0]     pair_up_c;
            logic [NP-1:0]     req_n;
            logic [NC-1:0]     grant_n;

            // Pair demand: OR of every requesting channel mapped onto the pair.
            always_comb begin
                demand_c = '0;
                for (int c = 0; c < NC; c++) begin
                    for (int p = 0; p < NP; p++) begin
                        if (chReq[c] && chPairMask[c*NP + p]) begin
                            demand_c[p] = 1'b1;
                        end
                    end
                end
            end

            // Per-pair handshake FSM: next state and hold-off counter.
            always_comb begin
                for (int p = 0; p < NP; p++) begin
                    state_n[p] = state_q[p];
                    hold_n[p]  = hold_q[p];
                    case (state_q[p])
                        ST_IDLE: begin
                            // ack while idle is ignored; only demand starts a handshake.
                            if (demand_c[p]) begin
                                state_n[p] = ST_REQ;
                            end
                        end
                        ST_REQ: begin
                            // A request is never withdrawn before it is acknowledged.
                            if (ackResources[p]) begin
                                state_n[p] = ST_ACTIVE;
                            end
                        end
                        ST_ACTIVE: begin
                            if (!demand_c[p]) begin
                                if (HOLD_CYCLES == 0) begin
                                    state_n[p] = ST_RELEASE;
                                end else begin
                                    state_n[p] = ST_HOLD;
                                    hold_n[p]  = HOLD_W'(HOLD_CYCLES);
                                end
                            end
                        end
                        ST_HOLD: begin
                            if (demand_c[p]) begin
                                state_n[p] = ST_ACTIVE;
                                hold_n[p]  = '0;
                            end else if (hold_q[p] == HOLD_W'(1)) begin
                                state_n[p] = ST_RELEASE;
                                hold_n[p]  = '0;
                            end else begin
                                hold_n[p]  = hold_q[p] - HOLD_W'(1);
                            end
                        end
                        ST_RELEASE: begin
                            // Wait for ack low; new demand is picked up from IDLE.
                            if (!ackResources[p]) begin
                                state_n[p] = ST_IDLE;
                            end
                        end
                        default: begin
                            state_n[p] = ST_IDLE;
                            hold_n[p]  = '0;
                        end
                    endcase
                end
            end

            // Request output follows the next state so it registers with it.
            always_comb begin
                for (int p = 0; p < NP; p++) begin
                    req_n[p]     = (state_n[p] == ST_REQ) || (state_n[p] == ST_ACTIVE) ||
                                   (state_n[p] == ST_HOLD);
                    pair_up_c[p] = (state_q[p] == ST_ACTIVE) || (state_q[p] == ST_HOLD);
                end
            end

            // Grant: channel demands and every pair it needs is up (vacuous for empty mask).
            always_comb begin
                for (int c = 0; c < NC; c++) begin
                    grant_n[c] = chReq[c];
                    for (int p = 0; p < NP; p++) begin
                        if (chPairMask[c*NP + p] && !pair_up_c[p]) begin
                            grant_n[c] = 1'b0;
                        end
                    end
                end
            end

            // State, counters and registered outputs.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int p = 0; p < NP; p++) begin
                        state_q[p] <= ST_IDLE;
                        hold_q[p]  <= '0;
                    end
                    reqResources <= '0;
                    chGrant      <= '0;
                end else begin
                    for (int p = 0; p < NP; p++) begin
                        state_q[p] <= state_n[p];
                        hold_q[p]  <= hold_n[p];
                    end
                    reqResources <= req_n;
                    chGrant      <= grant_n;
                end
            end

`ifdef EVENT_GENERATOR_UNIT_REQ_TIMEOUT_EN
            localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

            logic [TO_W-1:0] to_q [NP];
            logic [TO_W-1:0] to_n [NP];
            logic [NP-1:0]   flag_n;

            // Timeout counter: runs while waiting on ack, restarts on any state change,
            // saturates at the limit. The flag sets once on reaching the limit.
            always_comb begin
                for (int p = 0; p < NP; p++) begin
                    to_n[p]   = '0;
                    flag_n[p] = reqTimeout[p] & ~timeoutClear;
                    if ((state_n[p] == state_q[p]) &&
                        ((state_q[p] == ST_REQ) || (state_q[p] == ST_RELEASE))) begin
                        if (to_q[p] != TO_W'(TIMEOUT_CYCLES)) begin
                            to_n[p] = to_q[p] + TO_W'(1);
                            // Set wins over a simultaneous clear.
                            if (to_n[p] == TO_W'(TIMEOUT_CYCLES)) begin
                                flag_n[p] = 1'b1;
                            end
                        end else begin
                            to_n[p] = to_q[p];
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int p = 0; p < NP; p++) begin
                        to_q[p] <= '0;
                    end
                    reqTimeout <= '0;
                end else begin
                    for (int p = 0; p < NP; p++) begin
                        to_q[p] <= to_n[p];
                    end
                    reqTimeout <= flag_n;
                end
            end
`else
            logic unused_timeout;

            assign reqTimeout     = '0;
            assign unused_timeout = timeoutClear ^ (TIMEOUT_CYCLES == 0);
`endif

        end else begin : g_no_unit

            logic unused_inputs;

            assign reqResources  = '0;
            assign chGrant       = '0;
            assign reqTimeout    = '0;
            assign unused_inputs = ^{clk, reset, chReq, chPairMask, ackResources, timeoutClear};

        end
    endgenerate

endmodule
